// File: rtl/circuit5_seq_ctrl.sv
// Resource-shared circuit5 evaluator: one add/sub unit time-multiplexed by an FSM.
// Optional build macro CIRCUIT5_DEDICATED_CMP_EN replaces the CMP state with a comparator read in SUB_F.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// ADD_D | d = a + b
// ADD_E | e = a + c
// SUB_F | f = a - b (dedicated build also registers dLTe/dEQe here)
// CMP   | shared unit computes d - e for dLTe/dEQe (default build only)
// OUT   | select, shift, truncate; register x/z and pulse done
module circuit5_seq_ctrl #(
    parameter int DATAW = 64,
    parameter int OUTW  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DATAW-1:0] a,
    input  logic [DATAW-1:0] b,
    input  logic [DATAW-1:0] c,
    output logic             busy,
    output logic             done,
    output logic [OUTW-1:0]  x,
    output logic [OUTW-1:0]  z
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD_D = 3'd1,
        ADD_E = 3'd2,
        SUB_F = 3'd3,
        CMP   = 3'd4,
        OUT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DATAW-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DATAW-1:0]  d_q, d_d, e_q, e_d, f_q, f_d;
    logic              lt_q, lt_d, eq_q, eq_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [OUTW-1:0]   x_q, x_d, z_q, z_d;

    logic [DATAW:0]    op_a, op_b, sum;
    logic              op_sub;
    logic signed [DATAW-1:0] g, h;

`ifdef CIRCUIT5_DEDICATED_CMP_EN
    logic cmp_lt, cmp_eq;
    always_comb begin
        cmp_lt = $signed({d_q[DATAW-1], d_q}) < $signed({e_q[DATAW-1], e_q});
        cmp_eq = (d_q == e_q);
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        f_d     = f_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        x_d     = x_q;
        z_d     = z_q;

        // Shared unit: operands sign-extended one bit, subtract via invert plus carry-in.
        op_a   = {a_q[DATAW-1], a_q};
        op_b   = {b_q[DATAW-1], b_q};
        op_sub = 1'b0;
        case (state_q)
            ADD_E: op_b = {c_q[DATAW-1], c_q};
            SUB_F: op_sub = 1'b1;
            CMP: begin
                op_a   = {d_q[DATAW-1], d_q};
                op_b   = {e_q[DATAW-1], e_q};
                op_sub = 1'b1;
            end
            default: ;
        endcase
        sum = op_a + (op_sub ? ~op_b : op_b) + {{DATAW{1'b0}}, op_sub};

        g = lt_q ? e_q : d_q;
        h = eq_q ? f_q : g;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = c;
                    state_d = ADD_D;
                end
            end
            ADD_D: begin
                d_d     = DATAW'(sum);
                state_d = ADD_E;
            end
            ADD_E: begin
                e_d     = DATAW'(sum);
                state_d = SUB_F;
            end
            SUB_F: begin
                f_d     = DATAW'(sum);
`ifdef CIRCUIT5_DEDICATED_CMP_EN
                lt_d    = cmp_lt;
                eq_d    = cmp_eq;
                state_d = OUT;
`else
                state_d = CMP;
`endif
            end
`ifndef CIRCUIT5_DEDICATED_CMP_EN
            CMP: begin
                lt_d    = sum[DATAW];
                eq_d    = (sum == '0);
                state_d = OUT;
            end
`endif
            OUT: begin
                // Left shift done in DATAW+1 bits before truncation to the output width.
                x_d     = OUTW'({h[DATAW-1], h} << lt_q);
                z_d     = OUTW'(g >>> eq_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            f_q     <= f_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            x_q     <= x_d;
            z_q     <= z_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign x    = x_q;
    assign z    = z_q;

endmodule

// File: tb/tb_circuit5_seq_ctrl.sv
// Directed bench for circuit5_seq_ctrl; honours CIRCUIT5_DEDICATED_CMP_EN for the latency checks.
module tb_circuit5_seq_ctrl;

`ifdef CIRCUIT5_DEDICATED_CMP_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] a, b, c;
    logic        busy, done;
    logic [31:0] x, z;

    int tests = 0;
    int fails = 0;

    circuit5_seq_ctrl #(.DATAW(64), .OUTW(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .x     (x),
        .z     (z)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy length, results and done width.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic [63:0] tc,
                          input logic [31:0] ex, input logic [31:0] ez, input string tag);
        int lat;
        int bcnt;
        a = ta; b = tb_v; c = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
        check({63'd0, done}, 64'd1, {tag, "_done_seen"});
        check(64'(lat), 64'(LAT), {tag, "_latency"});
        check(64'(bcnt), 64'(LAT), {tag, "_busy_cycles"});
        check({32'd0, x}, {32'd0, ex}, {tag, "_x"});
        check({32'd0, z}, {32'd0, ez}, {tag, "_z"});
        tick();
        check({63'd0, done}, 64'd0, {tag, "_done_one_cycle"});
    endtask

    initial begin
        int dcnt;
        int first_i;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
        tick();
        tick();
        check({63'd0, busy}, 64'd0, "rst_busy");
        check({63'd0, done}, 64'd0, "rst_done");
        check({32'd0, x}, 64'd0, "rst_x");
        check({32'd0, z}, 64'd0, "rst_z");
        rst = 1'b0;
        tick();

        run_op(64'd10, 64'd3, 64'd5, 32'd30, 32'd15, "t1");
        run_op(64'd10, 64'd5, 64'd5, 32'd5, 32'd7, "t2");
        run_op(64'd0, -64'sd8, -64'sd20, 32'hFFFF_FFF8, 32'hFFFF_FFF8, "t3");
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
               32'hFFFF_FFFC, 32'hFFFF_FFFE, "t4");

        // start held high for 10 cycles: exactly two results
        a = 64'd10; b = 64'd3; c = 64'd5;
        start   = 1'b1;
        dcnt    = 0;
        first_i = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (done) begin
                dcnt++;
                if (first_i == 0) first_i = i;
            end
        end
        start = 1'b0;
        for (int i = 11; i <= 25; i++) begin
            tick();
            if (done) dcnt++;
        end
        check(64'(dcnt), 64'd2, "held_start_done_count");
        check(64'(first_i), 64'(LAT + 1), "held_start_first_done");
        check({32'd0, x}, 64'd30, "held_start_x");
        check({32'd0, z}, 64'd15, "held_start_z");

        // start pulse and operand changes while busy are ignored
        a = 64'd10; b = 64'd5; c = 64'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 64'd10; b = 64'd3; c = 64'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) dcnt++;
        end
        check(64'(dcnt), 64'd1, "busy_start_done_count");
        check({32'd0, x}, 64'd5, "busy_start_x");
        check({32'd0, z}, 64'd7, "busy_start_z");

        // reset while the compare step is in progress aborts without done
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check({63'd0, busy}, 64'd1, "abort_busy_before");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({63'd0, busy}, 64'd0, "abort_busy");
        check({63'd0, done}, 64'd0, "abort_done");
        check({32'd0, x}, 64'd0, "abort_x");
        check({32'd0, z}, 64'd0, "abort_z");
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dcnt++;
        end
        check(64'(dcnt), 64'd0, "abort_no_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
